// File: rtl/integrator_arbiter.sv
// integrator_arbiter: NCH signed saturating accumulators behind one shared adder.
// Channels compete for the adder through a round-robin arbiter. Defining
// INTEGRATOR_ARB_PRIO_EN switches to fixed priority, where the lowest index wins
// and there is no rotating pointer.
// Each accepted sample produces one registered result one cycle later.
module integrator_arbiter #(
  parameter int unsigned NCH = 4,
  parameter int unsigned W   = 10
) (
  input  logic                     system1000,
  input  logic                     system1000_rstn,
  input  logic [NCH-1:0]           req_valid,
  output logic [NCH-1:0]           req_ready,
  input  logic [NCH*W-1:0]         req_data,
  input  logic [NCH-1:0]           clr,
  output logic                     res_valid,
  output logic [$clog2(NCH)-1:0]   res_ch,
  output logic signed [W-1:0]      res_data
);

  localparam int unsigned CW = $clog2(NCH);
  localparam logic signed [W-1:0] ACC_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] ACC_MIN = {1'b1, {(W-1){1'b0}}};

  logic signed [W-1:0] r_acc [NCH];
  logic [CW-1:0]       w_idx;
  logic [CW-1:0]       w_gidx;
  logic                w_xfer;
  logic signed [W-1:0] w_gdata;
  logic signed [W-1:0] w_base;
  logic signed [W:0]   w_sum;
  logic signed [W-1:0] w_sat;

`ifndef INTEGRATOR_ARB_PRIO_EN
  logic [CW-1:0] r_ptr;
`endif

  // Grant selection: first valid channel scanning upward from the start point.
  always_comb begin
    w_idx     = '0;
    w_gidx    = '0;
    w_xfer    = 1'b0;
    req_ready = '0;
    for (int k = 0; k < NCH; k++) begin
`ifdef INTEGRATOR_ARB_PRIO_EN
      w_idx = CW'(k);
`else
      w_idx = r_ptr + CW'(k);
`endif
      if (!w_xfer && req_valid[w_idx]) begin
        w_xfer = 1'b1;
        w_gidx = w_idx;
      end
    end
    // No grant may be visible while reset is held.
    if (!system1000_rstn) begin
      w_xfer = 1'b0;
    end
    if (w_xfer) begin
      req_ready[w_gidx] = 1'b1;
    end
  end

  // Shared adder: clear-then-add when clr coincides, W+1 bit sum clipped to W bits.
  always_comb begin
    w_gdata = '0;
    for (int i = 0; i < NCH; i++) begin
      if (w_gidx == CW'(i)) begin
        w_gdata = req_data[i*W +: W];
      end
    end
    w_base = clr[w_gidx] ? '0 : r_acc[w_gidx];
    w_sum  = {w_base[W-1], w_base} + {w_gdata[W-1], w_gdata};
    case (w_sum[W:W-1])
      2'b01:   w_sat = ACC_MAX;
      2'b10:   w_sat = ACC_MIN;
      default: w_sat = w_sum[W-1:0];
    endcase
  end

  // Accumulator bank: granted channel takes the sum, other channels honour clr.
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      for (int i = 0; i < NCH; i++) begin
        r_acc[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (w_xfer && (w_gidx == CW'(i))) begin
          r_acc[i] <= w_sat;
        end else if (clr[i]) begin
          r_acc[i] <= '0;
        end
      end
    end
  end

  // Result port: strobe every transfer, hold channel/data between strobes.
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      res_valid <= 1'b0;
      res_ch    <= '0;
      res_data  <= '0;
    end else begin
      res_valid <= w_xfer;
      if (w_xfer) begin
        res_ch   <= w_gidx;
        res_data <= w_sat;
      end
    end
  end

`ifndef INTEGRATOR_ARB_PRIO_EN
  // Round-robin pointer: moves past the winner, holds when nothing is accepted.
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      r_ptr <= '0;
    end else if (w_xfer) begin
      r_ptr <= w_gidx + CW'(1);
    end
  end
`endif

endmodule
